alu_dest_router: RTL and testbench
==================================

Name: alu_dest_router

Overview:
- Parametrised successor of the ALU result demultiplexer. Routes each ALU/datapath result word to one of NUM_DEST destinations (data bus, register-file port A, stack push, ...) selected per transfer.
- Each destination has a registered one-entry holding slot with valid/ready handshakes on both sides, so a stalled destination never corrupts or loses a result.
- Sits between the ALU output and the register file, stack and data-bus write paths.

Parameters:
- WIDTH, 16, data word width in bits.
- NUM_DEST, 4, number of destination channels (2..16).
- SEL_W, 2, width of destination select; NUM_DEST <= 2**SEL_W.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  source offers a result word.
- in_ready  output  1  router accepts the word this cycle.
- in_data  input  WIDTH  result word.
- in_sel  input  SEL_W  destination index.
- out_valid  output  NUM_DEST  per-destination slot holds a word.
- out_ready  input  NUM_DEST  per-destination consumer takes the word.
- out_data  output  NUM_DEST*WIDTH  flattened slot data; channel k occupies bits [k*WIDTH +: WIDTH].
- sel_err  output  1  sticky flag: a word with in_sel >= NUM_DEST was accepted and dropped.

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, every out_data slice=0, sel_err=0, optional counter=0. Reset overrides any transfer in the same cycle. Words held in slots are discarded.
- Transfer on the input side = in_valid & in_ready at posedge. Transfer on the output side for channel k = out_valid[k] & out_ready[k] at posedge.
- slot_free[k] = ~out_valid[k] | out_ready[k]. A slot can refill in the same cycle it drains, giving full throughput of one word per cycle per channel.
- in_ready is combinational and does not depend on in_valid:
  - in_ready = slot_free[in_sel] when in_sel < NUM_DEST.
  - in_ready = 1 when in_sel >= NUM_DEST; the word is dropped.
- Accept to in_sel=k: out_data[k] <= in_data and out_valid[k] <= 1 at that edge. Latency is 1 cycle from accept to out_valid.
- Channel k drains with no concurrent accept to k: out_valid[k] <= 0. out_data[k] holds its last value.
- Simultaneous drain of k and accept to k: out_valid[k] stays 1 and data is replaced. No bubble.
- Channels other than in_sel are unaffected by input transfers. Multiple channels may drain in the same cycle.
- Accepted word with invalid select: no slot changes, sel_err <= 1, and sel_err stays 1 until reset.
- in_valid=0: no slot is written, whatever in_sel is.
- Output data is stable while out_valid[k]=1 and out_ready[k]=0 (hold rule).
- There is no state machine beyond the per-slot valid bit (EMPTY/FULL per channel):
  - EMPTY->FULL on accept.
  - FULL->EMPTY on drain without accept.
  - FULL->FULL on drain+accept or on stall.

Optional Feature:
- Macro ALU_DEST_ROUTER_STATS_EN.
- Defined:
  - Adds output port drop_cnt [7:0], incremented on every accepted invalid-select word, saturating at 255.
  - Adds output port stall_cnt [15:0], incremented each cycle in_valid=1 and in_ready=0, saturating at 65535.
  - Both counters clear on rst.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Decomposition:
- Package alu_dest_router_pkg holds the legacy destination encodings as constants: DEST_REG_A=0, DEST_STACK=1, DEST_DATA_BUS=3 (index 2 reserved). It also holds the default WIDTH/NUM_DEST/SEL_W values and the counter widths.
- One sub-module, alu_dest_slot: a one-entry valid/ready holding register (WIDTH parameter), instantiated NUM_DEST times via generate. The top level contains only the select decode, in_ready mux, sel_err and optional counters.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=4'b0000, all out_data=0, sel_err=0, in_ready=1 for every in_sel.
- Single route: in_data=16'hA5A5, in_sel=0, out_ready=4'b1111 -> next cycle out_valid=4'b0001 and out_data[15:0]=16'hA5A5; one cycle later out_valid=0.
- Backpressure: out_ready[1]=0, send 16'h1111 to sel=1 -> slot full, so a second send of 16'h2222 to sel=1 sees in_ready=0 and out_data[31:16] stays 16'h1111. Raise out_ready[1] -> 16'h1111 drains and 16'h2222 is accepted the same cycle, then appears next cycle.
- Streaming: 8 back-to-back words 16'h0001..16'h0008 to sel=3 with out_ready[3]=1 -> in_ready=1 throughout and out_data[63:48] shows 1..8 on consecutive cycles.
- Interleaved channels: stall channel 0 while streaming to channel 3 -> channel-3 traffic is unaffected and channel 0 holds its word.
- Invalid select and mid-operation reset: with NUM_DEST=3, sel=3 and 16'hDEAD -> accepted, no out_valid, sel_err=1 (drop_cnt=1 with the macro). Then rst with channel 1 full -> out_valid=0 and sel_err=0.

Source files
------------

// File: rtl/alu_dest_router_pkg.sv
// Shared constants for the ALU destination router: legacy destination
// encodings, default geometry and statistics counter widths.
package alu_dest_router_pkg;

  localparam int unsigned DEF_WIDTH    = 16;
  localparam int unsigned DEF_NUM_DEST = 4;
  localparam int unsigned DEF_SEL_W    = 2;

  localparam int unsigned DROP_CNT_W  = 8;
  localparam int unsigned STALL_CNT_W = 16;

  // Encoding 2 has no legacy consumer and stays reserved.
  typedef enum logic [1:0] {
    DEST_REG_A    = 2'd0,
    DEST_STACK    = 2'd1,
    DEST_RSVD     = 2'd2,
    DEST_DATA_BUS = 2'd3
  } dest_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/alu_dest_slot.sv
// One-entry valid/ready holding register for a single router destination.
module alu_dest_slot
  import alu_dest_router_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic             o_free,
  output logic [WIDTH-1:0] o_data
);

  slot_state_e      r_state;
  logic [WIDTH-1:0] r_data;

  // i_wr is only raised by the router while o_free is high, so a write
  // into a FULL slot always coincides with a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else begin
      case (r_state)
        SLOT_EMPTY: if (i_wr) r_state <= SLOT_FULL;
        SLOT_FULL:  if (i_ready && !i_wr) r_state <= SLOT_EMPTY;
        default:    r_state <= SLOT_EMPTY;
      endcase
      if (i_wr) r_data <= i_data;
    end
  end

  assign o_valid = (r_state == SLOT_FULL);
  assign o_free  = ~o_valid | i_ready;
  assign o_data  = r_data;

endmodule

// File: rtl/alu_dest_router.sv
// Routes ALU result words to one of NUM_DEST buffered destinations.
// Optional statistics counters: define ALU_DEST_ROUTER_STATS_EN.
module alu_dest_router
  import alu_dest_router_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned NUM_DEST = DEF_NUM_DEST,
  parameter int unsigned SEL_W    = DEF_SEL_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  output logic [NUM_DEST-1:0]       out_valid,
  input  logic [NUM_DEST-1:0]       out_ready,
  output logic [NUM_DEST*WIDTH-1:0] out_data,
  output logic                      sel_err
`ifdef ALU_DEST_ROUTER_STATS_EN
  ,
  output logic [DROP_CNT_W-1:0]     drop_cnt,
  output logic [STALL_CNT_W-1:0]    stall_cnt
`endif
);

  logic                w_sel_ok;
  logic [NUM_DEST-1:0] w_slot_free;
  logic [NUM_DEST-1:0] w_wr;
  logic                w_drop;
  logic                r_sel_err;

  assign w_sel_ok = (32'(in_sel) < NUM_DEST);

  // Out-of-range selects leave in_ready high so the word is swallowed.
  always_comb begin
    in_ready = 1'b1;
    w_wr     = '0;
    for (int unsigned k = 0; k < NUM_DEST; k++) begin
      if (32'(in_sel) == k) begin
        in_ready = w_slot_free[k];
        w_wr[k]  = in_valid & w_slot_free[k];
      end
    end
  end

  assign w_drop = in_valid & ~w_sel_ok;

  for (genvar k = 0; k < NUM_DEST; k++) begin : g_slot
    alu_dest_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .i_wr   (w_wr[k]),
      .i_data (in_data),
      .i_ready(out_ready[k]),
      .o_valid(out_valid[k]),
      .o_free (w_slot_free[k]),
      .o_data (out_data[k*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)         r_sel_err <= 1'b0;
    else if (w_drop) r_sel_err <= 1'b1;
  end

  assign sel_err = r_sel_err;

`ifdef ALU_DEST_ROUTER_STATS_EN
  logic [DROP_CNT_W-1:0]  r_drop_cnt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_drop && r_drop_cnt != '1)
        r_drop_cnt <= r_drop_cnt + 1'b1;
      if (in_valid && !in_ready && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign drop_cnt  = r_drop_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_alu_dest_router.sv
// Scoreboard bench for alu_dest_router built with three destinations so
// that select value 3 exercises the dropped-word path.
module tb_alu_dest_router;
  import alu_dest_router_pkg::*;

  localparam int ND = 3;
  localparam int W  = 16;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic [1:0]      in_sel;
  logic [ND-1:0]   out_valid;
  logic [ND-1:0]   out_ready;
  logic [ND*W-1:0] out_data;
  logic            sel_err;
`ifdef ALU_DEST_ROUTER_STATS_EN
  logic [7:0]      drop_cnt;
  logic [15:0]     stall_cnt;
`endif

  alu_dest_router #(
    .WIDTH   (W),
    .NUM_DEST(ND),
    .SEL_W   (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .sel_err  (sel_err)
`ifdef ALU_DEST_ROUTER_STATS_EN
    ,
    .drop_cnt (drop_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: each channel is a FIFO of words owed to its consumer,
  // plus the last word ever written (what the slot shows once drained).
  logic [W-1:0] q [ND][$];
  logic [W-1:0] last_wr [ND];
  logic         m_err;
  int           m_drop;
  int           m_stall;
  int           n_checks;
  int           n_err;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < ND; k++) begin
      q[k].delete();
      last_wr[k] = '0;
    end
    m_err   = 1'b0;
    m_drop  = 0;
    m_stall = 0;
  endtask

  // Drive one cycle of stimulus, predict in_ready and record any accept.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d,
                      input logic [1:0] s, input logic [ND-1:0] ordy);
    logic exp_rdy;
    @(posedge clk);
    #2;
    rst = r; in_valid = v; in_data = d; in_sel = s; out_ready = ordy;
    #2;
    if (r) begin
      model_reset();
    end else begin
      if (int'(s) >= ND) exp_rdy = 1'b1;
      else               exp_rdy = (q[s].size() == 0) || ordy[s];
      check($sformatf("in_ready sel=%0d", s), {31'd0, in_ready}, {31'd0, exp_rdy});
      if (v && exp_rdy) begin
        if (int'(s) < ND) begin
          q[s].push_back(d);
          last_wr[s] = d;
        end else begin
          m_err = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (v && !exp_rdy && m_stall < 65535) m_stall++;
    end
  endtask

  // Monitor: compares slot outputs after each edge, retires drained words.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < ND; k++) begin
        check($sformatf("out_valid[%0d]", k), {31'd0, out_valid[k]},
              {31'd0, q[k].size() != 0});
        check($sformatf("out_data[%0d]", k), {16'd0, out_data[k*W +: W]},
              {16'd0, (q[k].size() != 0) ? q[k][0] : last_wr[k]});
      end
      check("sel_err", {31'd0, sel_err}, {31'd0, m_err});
`ifdef ALU_DEST_ROUTER_STATS_EN
      check("drop_cnt", {24'd0, drop_cnt}, m_drop);
      check("stall_cnt", {16'd0, stall_cnt}, m_stall);
`endif
      #4;
      if (!rst) begin
        for (int k = 0; k < ND; k++) begin
          if (out_valid[k] && out_ready[k] && q[k].size() != 0)
            void'(q[k].pop_front());
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
    model_reset();

    step(1'b1, 1'b0, 16'h0, 2'd0, 3'b000);
    step(1'b1, 1'b0, 16'h0, 2'd0, 3'b000);
    for (int s = 0; s < 4; s++) step(1'b0, 1'b0, 16'hFFFF, 2'(s), 3'b000);

    // Single route then drain.
    step(1'b0, 1'b1, 16'hA5A5, DEST_REG_A, 3'b111);
    step(1'b0, 1'b0, 16'h0, 2'd0, 3'b111);
    step(1'b0, 1'b0, 16'h0, 2'd0, 3'b111);

    // Backpressure on channel 1, then drain+refill in one cycle.
    step(1'b0, 1'b1, 16'h1111, DEST_STACK, 3'b101);
    step(1'b0, 1'b1, 16'h2222, DEST_STACK, 3'b101);
    step(1'b0, 1'b1, 16'h2222, DEST_STACK, 3'b101);
    step(1'b0, 1'b1, 16'h2222, DEST_STACK, 3'b111);
    step(1'b0, 1'b0, 16'h0, 2'd0, 3'b111);
    step(1'b0, 1'b0, 16'h0, 2'd0, 3'b111);

    // Back-to-back stream to channel 2.
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 16'(i), 2'd2, 3'b111);

    // Channel 0 stalled while channel 2 streams.
    step(1'b0, 1'b1, 16'hC0C0, 2'd0, 3'b110);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'h3000 + 16'(i), 2'd2, 3'b110);
    step(1'b0, 1'b1, 16'hBAD0, 2'd0, 3'b110);
    step(1'b0, 1'b0, 16'h0, 2'd0, 3'b111);

    // Dropped select, then reset with channel 1 occupied.
    step(1'b0, 1'b1, 16'hDEAD, DEST_DATA_BUS, 3'b111);
    step(1'b0, 1'b1, 16'h7777, DEST_STACK, 3'b000);
    step(1'b0, 1'b0, 16'h0, 2'd0, 3'b000);
    step(1'b1, 1'b1, 16'h9999, DEST_STACK, 3'b000);
    step(1'b0, 1'b0, 16'h0, 2'd0, 3'b000);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] s;
      s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
           16'($urandom), s, 3'($urandom));
    end

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 2'd0, 3'b111);
    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
